rob_alloc: RTL and testbench

- Reorder-buffer entry allocator that sits directly upstream of the rename map.
- Hands out ROB entry addresses in program order; these drive the rename map's waddr ports.
- Retires entries from the head at commit and drives the rename map's single-entry invalidate (inve_/invaddr).
- Tracks occupancy, full and empty, and collapses all state on a pipeline flush.

---
 rtl/rob_alloc.sv | 112 +++++++++++
 tb/tb_rob_alloc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rob_alloc.sv
// Reorder-buffer entry allocator: in-order allocation at the tail, retirement at the head,
// registered rename-map invalidate. Optional stall counter under macro ROB_ALLOC_STAT_EN.
`ifndef RobDepth
`define RobDepth 16
`endif

module rob_alloc #(
    parameter  int DEPTH = `RobDepth,
    parameter  int ALLOC = 2,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [ALLOC-1:0]           req_,
    output logic                       alloc_ok,
    output logic [ALLOC-1:0][ADDR-1:0] alloc_addr,
    input  logic                       commit_,
    output logic [ADDR-1:0]            head_addr,
    input  logic                       flush_,
    output logic                       inve_,
    output logic [ADDR-1:0]            invaddr,
    output logic [ADDR:0]              count,
    output logic                       full,
    output logic                       empty,
    output logic [31:0]                stall_cnt
);

    localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] ONE     = (ADDR+1)'(1);

    logic [ADDR:0] head;
    logic [ADDR:0] tail;
    logic [ADDR:0] nreq;
    logic [ADDR:0] free_slots;
    logic          commit_acc;
    logic          prefix_done;

    assign count      = tail - head;
    assign full       = (count == DEPTH_W);
    assign empty      = (count == '0);
    assign head_addr  = head[ADDR-1:0];
    assign free_slots = DEPTH_W - count;
    assign commit_acc = !commit_ && !empty;

    // Only the contiguous run of active slots starting at slot 0 is counted.
    always_comb begin
        nreq        = '0;
        prefix_done = 1'b0;
        for (int k = 0; k < ALLOC; k++) begin
            if (!prefix_done && !req_[k]) begin
                nreq = nreq + ONE;
            end else begin
                prefix_done = 1'b1;
            end
        end
    end

    assign alloc_ok = (nreq != '0) && (free_slots >= nreq);

    always_comb begin
        for (int k = 0; k < ALLOC; k++) begin
            alloc_addr[k] = ADDR'(tail[ADDR-1:0] + ADDR'(k));
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            head    <= '0;
            tail    <= '0;
            inve_   <= 1'b1;
            invaddr <= '0;
        end else if (!flush_) begin
            head  <= '0;
            tail  <= '0;
            inve_ <= 1'b1;
        end else begin
            if (alloc_ok) begin
                tail <= tail + nreq;
            end
            if (commit_acc) begin
                head    <= head + ONE;
                invaddr <= head[ADDR-1:0];
            end
            inve_ <= !commit_acc;
        end
    end

`ifdef ROB_ALLOC_STAT_EN
    // Flush cycles are excluded: any grant then is void anyway.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            stall_cnt <= '0;
        end else if ((nreq != '0) && !alloc_ok && flush_ && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

`ifndef SYNTHESIS
    logic [ALLOC-1:0] req_low;
    assign req_low = ~req_;

    a_req_contiguous: assert property (@(posedge clk) disable iff (!reset_)
        ((req_low & (req_low + 1'b1)) == '0));

    a_commit_not_empty: assert property (@(posedge clk) disable iff (!reset_)
        !(!commit_ && empty));
`endif

endmodule

// File: tb/tb_rob_alloc.sv
// Randomized and directed bench for rob_alloc (DEPTH=16, ALLOC=2) against a queue-based model.
`timescale 1ns/1ps

module tb_rob_alloc;

    logic             clk;
    logic             reset_;
    logic [1:0]       req_;
    logic             alloc_ok;
    logic [1:0][3:0]  alloc_addr;
    logic             commit_;
    logic [3:0]       head_addr;
    logic             flush_;
    logic             inve_;
    logic [3:0]       invaddr;
    logic [4:0]       count;
    logic             full;
    logic             empty;
    logic [31:0]      stall_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: the queue holds the addresses of live entries in program order.
    int unsigned rob[$];
    int unsigned tail_seq = 0;
    bit          exp_inve = 1'b1;
    int unsigned exp_invaddr = 0;
    int unsigned exp_stall = 0;

    rob_alloc #(.DEPTH(16), .ALLOC(2)) dut (
        .clk(clk), .reset_(reset_), .req_(req_), .alloc_ok(alloc_ok),
        .alloc_addr(alloc_addr), .commit_(commit_), .head_addr(head_addr),
        .flush_(flush_), .inve_(inve_), .invaddr(invaddr), .count(count),
        .full(full), .empty(empty), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_head();
        return (rob.size() > 0) ? rob[0] : (tail_seq % 16);
    endfunction

    task automatic check_state();
        checkOutput("count", 32'(count), 32'(rob.size()));
        checkOutput("full", 32'(full), 32'(rob.size() == 16));
        checkOutput("empty", 32'(empty), 32'(rob.size() == 0));
        checkOutput("head_addr", 32'(head_addr), exp_head());
        checkOutput("inve_", 32'(inve_), 32'(exp_inve));
        checkOutput("invaddr", 32'(invaddr), exp_invaddr);
        checkOutput("stall_cnt", stall_cnt, exp_stall);
    endtask

    // One cycle: drive at negedge, check combinational grant, then registered state after the edge.
    task automatic applyStimulus(input logic [1:0] req, input logic commit, input logic flush);
        int  nreq;
        bit  ok;
        bit  commit_acc;
        req_    = req;
        commit_ = commit;
        flush_  = flush;
        nreq = (req[0] == 1'b0) ? ((req[1] == 1'b0) ? 2 : 1) : 0;
        ok   = (nreq > 0) && ((16 - rob.size()) >= nreq);
        commit_acc = (commit == 1'b0) && (rob.size() > 0);
        #1;
        checkOutput("alloc_ok", 32'(alloc_ok), 32'(ok));
        if (ok) begin
            checkOutput("alloc_addr0", 32'(alloc_addr[0]), tail_seq % 16);
            if (nreq == 2) checkOutput("alloc_addr1", 32'(alloc_addr[1]), (tail_seq + 1) % 16);
        end
`ifdef ROB_ALLOC_STAT_EN
        if ((nreq > 0) && !ok && flush && (exp_stall != 32'hFFFF_FFFF)) exp_stall++;
`endif
        @(posedge clk);
        if (!flush) begin
            rob.delete();
            tail_seq = 0;
            exp_inve = 1'b1;
        end else begin
            if (commit_acc) begin
                exp_invaddr = rob.pop_front();
                exp_inve    = 1'b0;
            end else begin
                exp_inve = 1'b1;
            end
            if (ok) begin
                for (int k = 0; k < nreq; k++) begin
                    rob.push_back(tail_seq % 16);
                    tail_seq++;
                end
            end
        end
        #1;
        check_state();
        @(negedge clk);
    endtask

    initial begin
        reset_  = 1'b0;
        req_    = 2'b11;
        commit_ = 1'b1;
        flush_  = 1'b1;
        #12;
        checkOutput("rst_alloc_ok", 32'(alloc_ok), 32'd0);
        checkOutput("rst_alloc_addr0", 32'(alloc_addr[0]), 32'd0);
        check_state();
        @(negedge clk);
        reset_ = 1'b1;

        // Fill in pairs, then a denied request at full.
        for (int i = 0; i < 8; i++) applyStimulus(2'b00, 1'b1, 1'b1);
        applyStimulus(2'b00, 1'b1, 1'b1);
        // Commit at full: same-cycle request denied, next single request wraps to 0.
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b10, 1'b1, 1'b1);

        // Fill to 15, two-slot denied, one-slot granted at address 15.
        applyStimulus(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(2'b00, 1'b1, 1'b1);
        applyStimulus(2'b10, 1'b1, 1'b1);
        applyStimulus(2'b00, 1'b1, 1'b1);
        applyStimulus(2'b10, 1'b1, 1'b1);

        // Stall while full, then flush with a request pending.
        for (int i = 0; i < 7; i++) applyStimulus(2'b00, 1'b1, 1'b1);
        applyStimulus(2'b00, 1'b1, 1'b0);

        // count=5 with head=3, then commit and allocate together.
        for (int i = 0; i < 4; i++) applyStimulus(2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b1);

        // Grow to 9, then flush with commit and request in the same cycle.
        applyStimulus(2'b00, 1'b1, 1'b1);
        applyStimulus(2'b10, 1'b1, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] r;
            logic       c;
            logic       f;
            case ($urandom_range(0, 2))
                0:       r = 2'b11;
                1:       r = 2'b10;
                default: r = 2'b00;
            endcase
            c = !((rob.size() > 0) && ($urandom_range(0, 99) < 45));
            f = !($urandom_range(0, 99) < 3);
            applyStimulus(r, c, f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
